riscv_core_div_in: RTL and testbench
====================================

Name: riscv_core_div_in

Overview:
Front-end sequencer for the iterative M-extension divider. It accepts a DIV/DIVU/REM/REMU (and W-variant) request from execute through a valid/ready handshake and registers the operands. It converts them to unsigned magnitudes, captures the dword and word sign bits, starts the divider core and holds context stable until the core finishes. Divide-by-zero and signed-overflow are resolved locally with a bypass result, so the divider core and the divider output stage are never started for them.

Parameters:
XLEN, 64, datapath width; the word width is XLEN/2 (localparam WLEN).

Ports:
i_clk  in  1  core clock
i_rst  in  1  asynchronous, active-high reset
i_div_in_valid  in  1  request from execute
o_div_in_ready  out  1  request accepted when valid&ready
i_div_in_srcA  in  XLEN  dividend
i_div_in_srcB  in  XLEN  divisor
i_div_in_control  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
i_div_in_isword  in  1  W-variant
i_div_in_flush  in  1  pipeline flush; abort the operation
o_div_in_start  out  1  one-cycle start pulse to the divider core
o_div_in_abort  out  1  one-cycle abort pulse to the divider core
o_div_in_dividend  out  XLEN  unsigned dividend magnitude
o_div_in_divisor  out  XLEN  unsigned divisor magnitude
i_div_in_done  in  1  divider core finished (quotient/remainder valid)
o_div_in_srcA_Dsign, o_div_in_srcB_Dsign  out  1 each  bit XLEN-1 of the operands
o_div_in_srcA_Wsign, o_div_in_srcB_Wsign  out  1 each  bit WLEN-1 of the operands
o_div_in_control  out  2  registered control, for the output stage
o_div_in_isword  out  1  registered isword
o_div_in_special  out  1  bypass result is selected
o_div_in_special_result  out  XLEN  final bypass result
o_div_in_result_valid  out  1  writeback may sample the result this cycle

Behaviour:
- FSM states: IDLE, START, BUSY, SPECIAL. The reset state is IDLE.
- Reset: all registered outputs are 0. o_div_in_ready=1 because it is decoded from IDLE.
- o_div_in_ready=1 only in IDLE. A request is accepted only on valid&ready.
- On accept, register the operands, control, isword, sign bits and magnitudes:
  - Sign bits are forced to 0 for unsigned ops (control[0]=1).
  - Signed dword magnitude: two's-complement absolute value of the operand.
  - Signed word magnitude: absolute value of the low WLEN bits taken as signed, zero-extended to XLEN.
  - Unsigned dword: operand unchanged. Unsigned word: low WLEN bits, zero-extended.
  - The most-negative value stays at its own magnitude (unsigned interpretation).
- Special-case detection, evaluated on the accept cycle using the effective width:
  - divisor==0: DIV* result is all ones; REM* result is the dividend (word variants sign-extend the low 32 bits).
  - Overflow, signed ops only: the dividend is the most-negative value and the divisor is -1. DIV result is the dividend (sign-extended for W). REM result is 0.
- Transitions:
  - IDLE -> SPECIAL on accept with a special case; IDLE -> START on any other accept.
  - START: o_div_in_start=1 for exactly one cycle, then BUSY.
  - BUSY: stay until i_div_in_done. In the done cycle o_div_in_result_valid=1 (combinational from done), then IDLE.
  - SPECIAL: o_div_in_special=1 and o_div_in_result_valid=1 for one cycle, then IDLE. No start pulse is issued.
- Latency: the start pulse and the special result both appear in cycle N+1 for an accept in cycle N. Ready reasserts in the cycle after done or SPECIAL.
- Magnitudes, signs, control and isword stay stable from the accept until the state returns to IDLE.
- Flush handling:
  - In START or BUSY: o_div_in_abort pulses for one cycle and the next state is IDLE. Result_valid is suppressed even if done arrives in the same cycle.
  - In SPECIAL: result_valid is suppressed.
  - In IDLE: the flush blocks the accept in that cycle.
  - Flush has priority over done and over accept.
- i_div_in_done outside BUSY is ignored.
- Asserting i_rst mid-operation returns the block to IDLE immediately and clears all outputs.

Decomposition:
- Package riscv_core_div_pkg holds:
  - the control localparams (DIV/DIVU/REM/REMU, which alias DIVW/DIVUW/REMW/REMUW);
  - the FSM state enum typedef.
- The output-stage module imports the same package.
- Sub-module riscv_core_div_special: combinational special-case detection plus bypass-result generation, driven by srcA, srcB, control and isword.

Test Plan:
1. DIV, srcA=0xFFFF_FFFF_FFFF_FFEC (-20), srcB=3 -> dividend=20, divisor=3, srcA_Dsign=1, srcB_Dsign=0. Start pulse in N+1. Ready=0 until the cycle after done. Result_valid only in the done cycle.
2. DIVU, srcA=0x1234, srcB=0 -> special=1, special_result=0xFFFF_FFFF_FFFF_FFFF, result_valid in N+1, no start pulse. REMU with the same operands -> special_result=0x1234.
3. DIVW, srcA=0x0000_0000_8000_0000, srcB=0xFFFF_FFFF_FFFF_FFFF -> special_result=0xFFFF_FFFF_8000_0000. REMW with the same operands -> special_result=0.
4. REMUW, srcA=0xFFFF_FFFF_0000_0007, srcB=5 -> dividend=7, divisor=5, all sign outputs 0, normal start.
5. Flush asserted in BUSY concurrently with done -> abort pulse, no result_valid, ready=1 next cycle. A done arriving later is ignored.
6. i_rst asserted mid-BUSY -> all outputs 0 asynchronously. After release, a new DIV request is accepted normally.

Source files
------------

// File: rtl/riscv_core_div_pkg.sv
// Shared definitions for the iterative divider: operation encodings and sequencer states.
package riscv_core_div_pkg;

  localparam int unsigned CTRL_W = 2;

  localparam logic [CTRL_W-1:0] CTRL_DIV   = 2'b00;
  localparam logic [CTRL_W-1:0] CTRL_DIVU  = 2'b01;
  localparam logic [CTRL_W-1:0] CTRL_REM   = 2'b10;
  localparam logic [CTRL_W-1:0] CTRL_REMU  = 2'b11;
  localparam logic [CTRL_W-1:0] CTRL_DIVW  = CTRL_DIV;
  localparam logic [CTRL_W-1:0] CTRL_DIVUW = CTRL_DIVU;
  localparam logic [CTRL_W-1:0] CTRL_REMW  = CTRL_REM;
  localparam logic [CTRL_W-1:0] CTRL_REMUW = CTRL_REMU;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_SPECIAL = 2'd3
  } div_state_e;

endpackage

// File: rtl/riscv_core_div_special.sv
// Divide-by-zero and signed-overflow detection with the architecturally defined bypass result.
module riscv_core_div_special
  import riscv_core_div_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  input  logic [CTRL_W-1:0] control,
  input  logic              isword,
  output logic              special_c,
  output logic [XLEN-1:0]   result_c
);

  localparam int unsigned WLEN = XLEN / 2;

  logic [XLEN-1:0] eff_a;
  logic            b_zero;
  logic            b_neg_one;
  logic            a_min;
  logic            overflow;
  logic            is_rem;

  always_comb begin
    eff_a     = isword ? {{WLEN{src_a[WLEN-1]}}, src_a[WLEN-1:0]} : src_a;
    b_zero    = isword ? (src_b[WLEN-1:0] == '0) : (src_b == '0);
    b_neg_one = isword ? (&src_b[WLEN-1:0]) : (&src_b);
    a_min     = isword ? (src_a[WLEN-1:0] == {1'b1, {(WLEN-1){1'b0}}})
                       : (src_a == {1'b1, {(XLEN-1){1'b0}}});
    is_rem    = control[1];
    overflow  = ~control[0] & a_min & b_neg_one;
    special_c = b_zero | overflow;
    result_c  = '0;
    if (b_zero) begin
      result_c = is_rem ? eff_a : '1;
    end else if (overflow) begin
      result_c = is_rem ? '0 : eff_a;
    end
  end

endmodule

// File: rtl/riscv_core_div_in.sv
// Divider front end: accepts a request, prepares unsigned operands and signs, sequences the core
// and resolves divide-by-zero / overflow locally.
module riscv_core_div_in
  import riscv_core_div_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_div_in_valid,
  output logic              o_div_in_ready,
  input  logic [XLEN-1:0]   i_div_in_srcA,
  input  logic [XLEN-1:0]   i_div_in_srcB,
  input  logic [CTRL_W-1:0] i_div_in_control,
  input  logic              i_div_in_isword,
  input  logic              i_div_in_flush,
  output logic              o_div_in_start,
  output logic              o_div_in_abort,
  output logic [XLEN-1:0]   o_div_in_dividend,
  output logic [XLEN-1:0]   o_div_in_divisor,
  input  logic              i_div_in_done,
  output logic              o_div_in_srcA_Dsign,
  output logic              o_div_in_srcB_Dsign,
  output logic              o_div_in_srcA_Wsign,
  output logic              o_div_in_srcB_Wsign,
  output logic [CTRL_W-1:0] o_div_in_control,
  output logic              o_div_in_isword,
  output logic              o_div_in_special,
  output logic [XLEN-1:0]   o_div_in_special_result,
  output logic              o_div_in_result_valid
);

  localparam int unsigned WLEN = XLEN / 2;

  div_state_e      state;
  logic            special_c;
  logic [XLEN-1:0] special_result_c;
  logic            is_signed;
  logic            accept;

  // Most-negative input maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] src,
                                                input logic            sgn,
                                                input logic            word);
    logic [WLEN-1:0] lo;
    lo = src[WLEN-1:0];
    if (word) begin
      if (sgn && lo[WLEN-1]) lo = WLEN'(0) - lo;
      return XLEN'(lo);
    end
    if (sgn && src[XLEN-1]) return XLEN'(0) - src;
    return src;
  endfunction

  riscv_core_div_special #(.XLEN(XLEN)) u_special (
    .src_a     (i_div_in_srcA),
    .src_b     (i_div_in_srcB),
    .control   (i_div_in_control),
    .isword    (i_div_in_isword),
    .special_c (special_c),
    .result_c  (special_result_c)
  );

  assign is_signed = ~i_div_in_control[0];
  assign accept    = i_div_in_valid & o_div_in_ready & ~i_div_in_flush;

  assign o_div_in_ready        = (state == ST_IDLE);
  assign o_div_in_start        = (state == ST_START);
  assign o_div_in_special      = (state == ST_SPECIAL);
  assign o_div_in_result_valid = ~i_div_in_flush &
                                 (((state == ST_BUSY) & i_div_in_done) | (state == ST_SPECIAL));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                   <= ST_IDLE;
      o_div_in_abort          <= 1'b0;
      o_div_in_dividend       <= '0;
      o_div_in_divisor        <= '0;
      o_div_in_srcA_Dsign     <= 1'b0;
      o_div_in_srcB_Dsign     <= 1'b0;
      o_div_in_srcA_Wsign     <= 1'b0;
      o_div_in_srcB_Wsign     <= 1'b0;
      o_div_in_control        <= '0;
      o_div_in_isword         <= 1'b0;
      o_div_in_special_result <= '0;
    end else begin
      o_div_in_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            o_div_in_dividend       <= magnitude(i_div_in_srcA, is_signed, i_div_in_isword);
            o_div_in_divisor        <= magnitude(i_div_in_srcB, is_signed, i_div_in_isword);
            o_div_in_srcA_Dsign     <= is_signed & i_div_in_srcA[XLEN-1];
            o_div_in_srcB_Dsign     <= is_signed & i_div_in_srcB[XLEN-1];
            o_div_in_srcA_Wsign     <= is_signed & i_div_in_srcA[WLEN-1];
            o_div_in_srcB_Wsign     <= is_signed & i_div_in_srcB[WLEN-1];
            o_div_in_control        <= i_div_in_control;
            o_div_in_isword         <= i_div_in_isword;
            o_div_in_special_result <= special_result_c;
            state                   <= special_c ? ST_SPECIAL : ST_START;
          end
        end
        ST_START: begin
          if (i_div_in_flush) begin
            o_div_in_abort <= 1'b1;
            state          <= ST_IDLE;
          end else begin
            state <= ST_BUSY;
          end
        end
        // Flush outranks done: the core result is discarded.
        ST_BUSY: begin
          if (i_div_in_flush) begin
            o_div_in_abort <= 1'b1;
            state          <= ST_IDLE;
          end else if (i_div_in_done) begin
            state <= ST_IDLE;
          end
        end
        ST_SPECIAL: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_core_div_in.sv
// Self-checking bench for riscv_core_div_in: directed test-plan steps plus randomized requests
// checked against an arithmetic reference model.
module tb_riscv_core_div_in;
  import riscv_core_div_pkg::*;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [1:0]      ctrl;
  logic            isword;
  logic            flush;
  logic            start;
  logic            abort;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            done;
  logic            a_dsign, b_dsign, a_wsign, b_wsign;
  logic [1:0]      ctrl_q;
  logic            isword_q;
  logic            special;
  logic [XLEN-1:0] special_result;
  logic            result_valid;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        a_dsign, b_dsign, a_wsign, b_wsign;
    logic        special;
    logic [63:0] result;
  } exp_t;

  riscv_core_div_in #(.XLEN(XLEN)) dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_div_in_valid          (valid),
    .o_div_in_ready          (ready),
    .i_div_in_srcA           (src_a),
    .i_div_in_srcB           (src_b),
    .i_div_in_control        (ctrl),
    .i_div_in_isword         (isword),
    .i_div_in_flush          (flush),
    .o_div_in_start          (start),
    .o_div_in_abort          (abort),
    .o_div_in_dividend       (dividend),
    .o_div_in_divisor        (divisor),
    .i_div_in_done           (done),
    .o_div_in_srcA_Dsign     (a_dsign),
    .o_div_in_srcB_Dsign     (b_dsign),
    .o_div_in_srcA_Wsign     (a_wsign),
    .o_div_in_srcB_Wsign     (b_wsign),
    .o_div_in_control        (ctrl_q),
    .o_div_in_isword         (isword_q),
    .o_div_in_special        (special),
    .o_div_in_special_result (special_result),
    .o_div_in_result_valid   (result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: RISC-V M-extension semantics evaluated with signed integer arithmetic.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] c, input logic w);
    exp_t   e;
    logic   sgn, rem, dz, ovf;
    longint sa, sb;
    logic [63:0] a_ext;
    sgn = (c == CTRL_DIV) || (c == CTRL_REM);
    rem = (c == CTRL_REM) || (c == CTRL_REMU);
    if (w) begin
      sa = longint'($signed(a[31:0]));
      sb = longint'($signed(b[31:0]));
      a_ext = 64'(sa);
      e.dividend = sgn ? ((sa < 0 ? -sa : sa) & 64'h0000_0000_FFFF_FFFF) : {32'h0, a[31:0]};
      e.divisor  = sgn ? ((sb < 0 ? -sb : sb) & 64'h0000_0000_FFFF_FFFF) : {32'h0, b[31:0]};
      dz  = (b[31:0] == 32'h0);
      ovf = sgn && (sa == -longint'(64'h8000_0000)) && (sb == -1);
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      a_ext = a;
      e.dividend = (sgn && sa < 0) ? 64'(-sa) : a;
      e.divisor  = (sgn && sb < 0) ? 64'(-sb) : b;
      dz  = (b == 64'h0);
      ovf = sgn && (a == 64'h8000_0000_0000_0000) && (sb == -1);
    end
    e.a_dsign = sgn & a[63];
    e.b_dsign = sgn & b[63];
    e.a_wsign = sgn & a[31];
    e.b_wsign = sgn & b[31];
    e.special = dz | ovf;
    e.result  = 64'h0;
    if (dz)       e.result = rem ? a_ext : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (ovf) e.result = rem ? 64'h0 : a_ext;
    return e;
  endfunction

  // Full request: accept, check N+1 outputs, run the core for 'busy' cycles, then complete.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] c, input logic w, input int busy);
    exp_t e;
    e = model(a, b, c, w);
    chk({tag, ":ready_idle"}, 64'(ready), 64'd1);
    valid = 1'b1; src_a = a; src_b = b; ctrl = c; isword = w;
    tick();
    valid = 1'b0;
    src_a = {$urandom, $urandom}; src_b = {$urandom, $urandom};
    ctrl = 2'($urandom); isword = 1'($urandom);
    #1;
    chk({tag, ":ready_n1"},    64'(ready), 64'd0);
    chk({tag, ":start_n1"},    64'(start), 64'(!e.special));
    chk({tag, ":special_n1"},  64'(special), 64'(e.special));
    chk({tag, ":rv_n1"},       64'(result_valid), 64'(e.special));
    chk({tag, ":dividend"},    dividend, e.dividend);
    chk({tag, ":divisor"},     divisor, e.divisor);
    chk({tag, ":signs"},       64'({a_dsign, b_dsign, a_wsign, b_wsign}),
                               64'({e.a_dsign, e.b_dsign, e.a_wsign, e.b_wsign}));
    chk({tag, ":ctrl_word"},   64'({ctrl_q, isword_q}), 64'({c, w}));
    if (e.special) begin
      chk({tag, ":special_res"}, special_result, e.result);
      tick();
    end else begin
      tick();
      chk({tag, ":start_once"}, 64'(start), 64'd0);
      for (int i = 0; i < busy; i++) begin
        chk({tag, ":busy_rv"},    64'(result_valid), 64'd0);
        chk({tag, ":busy_ready"}, 64'(ready), 64'd0);
        tick();
      end
      done = 1'b1;
      #1;
      chk({tag, ":rv_done"},       64'(result_valid), 64'd1);
      chk({tag, ":ready_done"},    64'(ready), 64'd0);
      chk({tag, ":dividend_hold"}, dividend, e.dividend);
      tick();
      done = 1'b0;
    end
    #1;
    chk({tag, ":ready_after"}, 64'(ready), 64'd1);
    chk({tag, ":rv_after"},    64'(result_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    rst = 1'b1; valid = 1'b0; src_a = '0; src_b = '0; ctrl = '0; isword = 1'b0;
    flush = 1'b0; done = 1'b0;
    #12;
    chk("rst:ready",  64'(ready), 64'd1);
    chk("rst:outs",   64'({start, abort, special, result_valid, a_dsign, b_dsign, a_wsign, b_wsign,
                           isword_q, ctrl_q}), 64'd0);
    chk("rst:data",   dividend | divisor | special_result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 1: signed dword divide, normal path.
    do_op("t1_div", 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, CTRL_DIV, 1'b0, 3);
    chk("t1:dividend_val", dividend, 64'd20);
    // 2: divide by zero, both DIVU and REMU.
    do_op("t2_divu0", 64'h1234, 64'd0, CTRL_DIVU, 1'b0, 0);
    do_op("t2_remu0", 64'h1234, 64'd0, CTRL_REMU, 1'b0, 0);
    // 3: word overflow.
    do_op("t3_divw_ovf", 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, CTRL_DIVW, 1'b1, 0);
    do_op("t3_remw_ovf", 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, CTRL_REMW, 1'b1, 0);
    // 4: unsigned word remainder ignores upper bits.
    do_op("t4_remuw", 64'hFFFF_FFFF_0000_0007, 64'd5, CTRL_REMUW, 1'b1, 1);
    // Dword overflow and most-negative magnitude.
    do_op("dw_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, CTRL_DIV, 1'b0, 0);
    do_op("dw_min", 64'h8000_0000_0000_0000, 64'd7, CTRL_REM, 1'b0, 2);

    // 5: flush in BUSY together with done.
    valid = 1'b1; src_a = 64'd100; src_b = 64'd7; ctrl = CTRL_DIV; isword = 1'b0;
    tick();
    valid = 1'b0;
    tick();
    tick();
    flush = 1'b1; done = 1'b1;
    #1;
    chk("t5:rv_flush", 64'(result_valid), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("t5:abort",      64'(abort), 64'd1);
    chk("t5:ready_next", 64'(ready), 64'd1);
    chk("t5:late_done_rv", 64'(result_valid), 64'd0);
    tick();
    done = 1'b0;
    #1;
    chk("t5:abort_once", 64'(abort), 64'd0);
    chk("t5:late_done_ignored", 64'({ready, start}), 64'b10);
    // Flush in IDLE blocks the accept.
    valid = 1'b1; flush = 1'b1;
    tick();
    valid = 1'b0; flush = 1'b0;
    #1;
    chk("idle_flush:ready", 64'(ready), 64'd1);
    chk("idle_flush:start", 64'(start), 64'd0);
    // Flush in SPECIAL suppresses result_valid.
    valid = 1'b1; src_a = 64'd9; src_b = 64'd0; ctrl = CTRL_DIVU; isword = 1'b0;
    tick();
    valid = 1'b0; flush = 1'b1;
    #1;
    chk("spec_flush:special", 64'(special), 64'd1);
    chk("spec_flush:rv",      64'(result_valid), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("spec_flush:ready", 64'(ready), 64'd1);

    // 6: asynchronous reset mid-BUSY.
    valid = 1'b1; src_a = 64'hFFFF_FFFF_FFFF_FF00; src_b = 64'd3; ctrl = CTRL_DIV; isword = 1'b0;
    tick();
    valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t6:ready",  64'(ready), 64'd1);
    chk("t6:outs",   64'({start, abort, special, result_valid, a_dsign, b_dsign, a_wsign, b_wsign,
                          isword_q, ctrl_q}), 64'd0);
    chk("t6:data",   dividend | divisor | special_result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    do_op("t6_after", 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, CTRL_DIV, 1'b0, 1);

    // Randomized requests, biased toward the special-case operands.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       ra = 64'h8000_0000_0000_0000;
        1:       ra = {32'($urandom), 32'h8000_0000};
        default: ra = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 4))
        0:       rb = 64'h0;
        1:       rb = {32'($urandom), 32'h0};
        2:       rb = 64'hFFFF_FFFF_FFFF_FFFF;
        3:       rb = {32'($urandom), 32'hFFFF_FFFF};
        default: rb = {$urandom, $urandom};
      endcase
      do_op("rand", ra, rb, 2'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
